// File: rtl/bbq_resp_collector.sv
// rtl/bbq_resp_collector.sv - merges two heap response streams into one issue-ordered dequeue result stream
// Optional feature macro: BBQ_RESP_BYPASS_EN (an arriving result for the head tag skips its empty FIFO)
package heap_ops;
  typedef enum logic [1:0] {
    HEAP_OP_ENQUE     = 2'd0,
    HEAP_OP_DEQUE_MIN = 2'd1,
    HEAP_OP_DEQUE_MAX = 2'd2,
    HEAP_OP_REPLACE   = 2'd3
  } heap_op_t;
endpackage

module bbq_resp_collector
  import heap_ops::*;
#(
  parameter int DWIDTH      = 32,
  parameter int PRIOR_WIDTH = 6,
  parameter int TAG_DEPTH   = 8,
  parameter int RESP_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic                   issue_port,
  output logic                   issue_ready,
  input  logic                   in_0_valid,
  input  heap_op_t               in_0_op_type,
  input  logic [DWIDTH-1:0]      in_0_he_data,
  input  logic [PRIOR_WIDTH-1:0] in_0_he_priority,
  input  logic                   in_1_valid,
  input  heap_op_t               in_1_op_type,
  input  logic [DWIDTH-1:0]      in_1_he_data,
  input  logic [PRIOR_WIDTH-1:0] in_1_he_priority,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [DWIDTH-1:0]      resp_data,
  output logic [PRIOR_WIDTH-1:0] resp_priority,
  output logic                   err_overflow,
  output logic                   err_unexpected
);
  localparam int TAW = $clog2(TAG_DEPTH);
  localparam int RAW = $clog2(RESP_DEPTH);
  localparam int CW  = $clog2(TAG_DEPTH + 1);
  localparam int EW  = DWIDTH + PRIOR_WIDTH;

  logic [TAG_DEPTH-1:0] tag_mem;
  logic [TAW:0]         tag_wr, tag_rd;
  logic [EW-1:0]        resp_mem [2][RESP_DEPTH];
  logic [RAW:0]         resp_wr [2];
  logic [RAW:0]         resp_rd [2];
  logic [CW-1:0]        outst [2];
  logic                 out_valid;
  logic [EW-1:0]        out_elem;
  logic                 err_ovf_q, err_unx_q;

  logic [1:0]           in_valid;
  heap_op_t             in_op [2];
  logic [EW-1:0]        in_elem [2];

  logic                 tag_empty, tag_full, issue_fire, head, out_free;
  logic                 load_fifo, load_byp;
  logic [1:0]           resp_empty, resp_full, is_deq, pop, acc, push, unexp, ovf, iss;
  logic [EW-1:0]        load_elem;

  assign in_valid   = {in_1_valid, in_0_valid};
  assign in_op[0]   = in_0_op_type;
  assign in_op[1]   = in_1_op_type;
  assign in_elem[0] = {in_0_he_data, in_0_he_priority};
  assign in_elem[1] = {in_1_he_data, in_1_he_priority};

  // Queue status, response filtering, merge selection and optional bypass
  always_comb begin
    tag_empty  = (tag_wr == tag_rd);
    tag_full   = (tag_wr[TAW] != tag_rd[TAW]) && (tag_wr[TAW-1:0] == tag_rd[TAW-1:0]);
    issue_fire = issue_valid && !tag_full;
    head       = tag_mem[tag_rd[TAW-1:0]];
    out_free   = !out_valid || resp_ready;
    resp_empty = '0;
    resp_full  = '0;
    is_deq     = '0;
    iss        = '0;
    pop        = '0;
    acc        = '0;
    unexp      = '0;
    ovf        = '0;
    push       = '0;
    for (int p = 0; p < 2; p++) begin
      resp_empty[p] = (resp_wr[p] == resp_rd[p]);
      resp_full[p]  = (resp_wr[p][RAW] != resp_rd[p][RAW]) &&
                      (resp_wr[p][RAW-1:0] == resp_rd[p][RAW-1:0]);
      is_deq[p]     = in_valid[p] && (in_op[p] != HEAP_OP_ENQUE);
      iss[p]        = issue_fire && (issue_port == 1'(p));
    end
    load_fifo = out_free && !tag_empty && !resp_empty[head];
    for (int p = 0; p < 2; p++) begin
      pop[p]   = load_fifo && (head == 1'(p));
      acc[p]   = is_deq[p] && (outst[p] != '0) && (!resp_full[p] || pop[p]);
      unexp[p] = is_deq[p] && (outst[p] == '0);
      ovf[p]   = is_deq[p] && (outst[p] != '0) && resp_full[p] && !pop[p];
    end
`ifdef BBQ_RESP_BYPASS_EN
    load_byp = out_free && !tag_empty && resp_empty[head] && acc[head];
`else
    load_byp = 1'b0;
`endif
    for (int p = 0; p < 2; p++) begin
      push[p] = acc[p] && !(load_byp && (head == 1'(p)));
    end
    load_elem = load_byp ? in_elem[head] : resp_mem[head][resp_rd[head][RAW-1:0]];
  end

  // Tag FIFO pointers: push on issue, pop when the output register loads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_wr <= '0;
      tag_rd <= '0;
    end else begin
      if (issue_fire) tag_wr <= tag_wr + (TAW+1)'(1);
      if (load_fifo || load_byp) tag_rd <= tag_rd + (TAW+1)'(1);
    end
  end

  // Storage arrays carry no reset; pointers define what is valid
  always_ff @(posedge clk) begin
    if (issue_fire) tag_mem[tag_wr[TAW-1:0]] <= issue_port;
    for (int p = 0; p < 2; p++) begin
      if (push[p]) resp_mem[p][resp_wr[p][RAW-1:0]] <= in_elem[p];
    end
  end

  // Per-port response FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        resp_wr[p] <= '0;
        resp_rd[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (push[p]) resp_wr[p] <= resp_wr[p] + (RAW+1)'(1);
        if (pop[p])  resp_rd[p] <= resp_rd[p] + (RAW+1)'(1);
      end
    end
  end

  // Outstanding dequeues per port; an accept implies nonzero so no underflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) outst[p] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (iss[p] && !acc[p])      outst[p] <= outst[p] + CW'(1);
        else if (!iss[p] && acc[p]) outst[p] <= outst[p] - CW'(1);
      end
    end
  end

  // Output register: load from head FIFO (or bypass), otherwise drain on ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_elem  <= '0;
    end else if (load_fifo || load_byp) begin
      out_valid <= 1'b1;
      out_elem  <= load_elem;
    end else if (resp_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
      err_unx_q <= 1'b0;
    end else begin
      if (|ovf)   err_ovf_q <= 1'b1;
      if (|unexp) err_unx_q <= 1'b1;
    end
  end

  assign issue_ready    = !tag_full;
  assign resp_valid     = out_valid;
  assign resp_data      = out_elem[EW-1:PRIOR_WIDTH];
  assign resp_priority  = out_elem[PRIOR_WIDTH-1:0];
  assign err_overflow   = err_ovf_q;
  assign err_unexpected = err_unx_q;

endmodule

// File: tb/tb_bbq_resp_collector.sv
// tb/tb_bbq_resp_collector.sv - self-checking bench for bbq_resp_collector with a queue-based reference model
module tb_bbq_resp_collector;
  import heap_ops::*;

  localparam int DW = 32;
  localparam int PW = 6;
  localparam int TD = 8;
  localparam int RD = 4;
  localparam int EW = DW + PW;
`ifdef BBQ_RESP_BYPASS_EN
  localparam int BASE_LAT = 1;
`else
  localparam int BASE_LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue_valid = 1'b0;
  logic          issue_port = 1'b0;
  logic          resp_ready = 1'b1;
  logic          in_valid [2];
  heap_op_t      in_op [2];
  logic [DW-1:0] in_data [2];
  logic [PW-1:0] in_prio [2];
  logic          issue_ready, resp_valid, err_overflow, err_unexpected;
  logic [DW-1:0] resp_data;
  logic [PW-1:0] resp_priority;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit            tagq[$];
  logic [EW-1:0] rq0[$];
  logic [EW-1:0] rq1[$];
  int            m_outst [2];
  bit            mv = 1'b0;
  logic [EW-1:0] md = '0;
  bit            m_ovf = 1'b0;
  bit            m_unx = 1'b0;
  logic [DW-1:0] got[$];

  bbq_resp_collector #(.DWIDTH(DW), .PRIOR_WIDTH(PW), .TAG_DEPTH(TD), .RESP_DEPTH(RD)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_port(issue_port), .issue_ready(issue_ready),
    .in_0_valid(in_valid[0]), .in_0_op_type(in_op[0]),
    .in_0_he_data(in_data[0]), .in_0_he_priority(in_prio[0]),
    .in_1_valid(in_valid[1]), .in_1_op_type(in_op[1]),
    .in_1_he_data(in_data[1]), .in_1_he_priority(in_prio[1]),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_priority(resp_priority),
    .err_overflow(err_overflow), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    tagq.delete();
    rq0.delete();
    rq1.delete();
    m_outst[0] = 0;
    m_outst[1] = 0;
    mv = 1'b0;
    md = '0;
    m_ovf = 1'b0;
    m_unx = 1'b0;
  endtask

  // One clock of the abstract behaviour: strict issue order, per-port queues, counts of pending dequeues
  task automatic model_step();
    bit            tv, h, fire, byp, ld, free;
    int            sz [2];
    bit            isdeq [2];
    bit            pop [2];
    bit            acc [2];
    logic [EW-1:0] el [2];
    logic [EW-1:0] nv;
    sz[0] = rq0.size();
    sz[1] = rq1.size();
    tv    = tagq.size() != 0;
    h     = tv ? tagq[0] : 1'b0;
    fire  = issue_valid && (tagq.size() < TD);
    free  = !mv || resp_ready;
    ld    = 1'b0;
    byp   = 1'b0;
    nv    = '0;
    for (int p = 0; p < 2; p++) begin
      el[p]    = {in_data[p], in_prio[p]};
      isdeq[p] = in_valid[p] && (in_op[p] != HEAP_OP_ENQUE);
      pop[p]   = free && tv && (int'(h) == p) && (sz[p] > 0);
    end
    for (int p = 0; p < 2; p++) begin
      acc[p] = isdeq[p] && (m_outst[p] > 0) && ((sz[p] < RD) || pop[p]);
      if (isdeq[p] && m_outst[p] == 0) m_unx = 1'b1;
      if (isdeq[p] && m_outst[p] > 0 && !acc[p]) m_ovf = 1'b1;
    end
    if (BASE_LAT == 1 && free && tv && sz[h] == 0 && acc[h]) byp = 1'b1;
    if (pop[h]) begin
      if (h) nv = rq1.pop_front();
      else   nv = rq0.pop_front();
      ld = 1'b1;
    end else if (byp) begin
      nv = el[h];
      ld = 1'b1;
    end
    if (ld) begin
      mv = 1'b1;
      md = nv;
      void'(tagq.pop_front());
    end else if (resp_ready) begin
      mv = 1'b0;
    end
    if (acc[0] && !(byp && h == 1'b0)) rq0.push_back(el[0]);
    if (acc[1] && !(byp && h == 1'b1)) rq1.push_back(el[1]);
    if (fire) tagq.push_back(issue_port);
    for (int p = 0; p < 2; p++) begin
      if (fire && int'(issue_port) == p) m_outst[p]++;
      if (acc[p]) m_outst[p]--;
    end
  endtask

  // Advance the model on every clock; async reset clears it immediately
  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      check("resp_valid", resp_valid, mv);
      if (mv) begin
        check("resp_data", resp_data, md[EW-1:PW]);
        check("resp_priority", resp_priority, md[PW-1:0]);
      end
      check("issue_ready", issue_ready, tagq.size() < TD);
      check("err_overflow", err_overflow, m_ovf);
      check("err_unexpected", err_unexpected, m_unx);
      if (resp_valid && resp_ready) got.push_back(resp_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    issue_valid = 1'b0;
    for (int p = 0; p < 2; p++) begin
      in_valid[p] = 1'b0;
      in_op[p]    = HEAP_OP_ENQUE;
      in_data[p]  = '0;
      in_prio[p]  = '0;
    end
  endtask

  task automatic send(input int p, input heap_op_t op, input logic [DW-1:0] d, input logic [PW-1:0] pr);
    in_valid[p] = 1'b1;
    in_op[p]    = op;
    in_data[p]  = d;
    in_prio[p]  = pr;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic issue_n(input int n, input logic port);
    issue_valid = 1'b1;
    issue_port  = port;
    repeat (n) tick();
    issue_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int            lat;
    int            avail [2];
    bit            fired;
    logic          fport;
    logic [DW-1:0] exp2 [3];
    logic [DW-1:0] g;

    clr_in();
    resp_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_resp_priority", resp_priority, 6'h0);
    check("rst_err_overflow", err_overflow, 1'b0);
    check("rst_err_unexpected", err_unexpected, 1'b0);
    rst = 1'b0;
    tick();
    check("rst_issue_ready", issue_ready, 1'b1);

    // basic latency
    issue_n(1, 1'b0);
    tick();
    send(0, HEAP_OP_DEQUE_MIN, 32'hA5, 6'd3);
    tick();
    clr_in();
    lat = 1;
    while (!resp_valid && lat < 8) begin
      tick();
      lat++;
    end
    check("t1_latency", lat, BASE_LAT);
    check("t1_data", resp_data, 32'hA5);
    check("t1_priority", resp_priority, 6'd3);
    tick();
    check("t1_one_cycle", resp_valid, 1'b0);

    // strict issue order across ports
    got.delete();
    issue_n(1, 1'b0);
    issue_n(1, 1'b1);
    issue_n(1, 1'b0);
    send(1, HEAP_OP_DEQUE_MAX, 32'h11, 6'd1);
    tick();
    clr_in();
    tick();
    tick();
    check("t2_no_early_output", got.size(), 0);
    send(0, HEAP_OP_DEQUE_MAX, 32'h20, 6'd2);
    tick();
    send(0, HEAP_OP_DEQUE_MAX, 32'h30, 6'd3);
    tick();
    clr_in();
    repeat (6) tick();
    exp2[0] = 32'h20;
    exp2[1] = 32'h11;
    exp2[2] = 32'h30;
    check("t2_count", got.size(), 3);
    for (int i = 0; i < 3; i++) begin
      g = (i < got.size()) ? got[i] : '1;
      check($sformatf("t2_order_%0d", i), g, exp2[i]);
    end

    // enqueue acks are invisible
    got.delete();
    send(0, HEAP_OP_ENQUE, 32'h77, 6'd7);
    tick();
    clr_in();
    repeat (3) tick();
    check("t3_no_output", got.size(), 0);
    check("t3_no_overflow", err_overflow, 1'b0);
    check("t3_no_unexpected", err_unexpected, 1'b0);

    // unexpected response
    send(1, HEAP_OP_DEQUE_MIN, 32'h99, 6'd9);
    tick();
    clr_in();
    check("t4_unexpected_set", err_unexpected, 1'b1);
    repeat (5) tick();
    check("t4_unexpected_sticky", err_unexpected, 1'b1);
    check("t4_dropped", got.size(), 0);

    // overflow and tag FIFO full
    do_reset();
    resp_ready = 1'b0;
    issue_n(6, 1'b0);
    tick();
    for (int i = 0; i < 6; i++) begin
      send(0, HEAP_OP_DEQUE_MIN, 32'h100 + i, 6'(i));
      tick();
    end
    clr_in();
    tick();
    tick();
    check("t5_overflow", err_overflow, 1'b1);
    check("t5_head_valid", resp_valid, 1'b1);
    check("t5_head_data", resp_data, 32'h100);
    check("t5_no_unexpected", err_unexpected, 1'b0);
    issue_n(8, 1'b1);
    check("t5_tags_full", issue_ready, 1'b0);

    // async reset mid-stream
    do_reset();
    resp_ready = 1'b0;
    issue_n(3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send(0, HEAP_OP_DEQUE_MAX, 32'h200 + i, 6'd5);
      tick();
    end
    clr_in();
    repeat (3) tick();
    check("t6_queued_valid", resp_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_clear", resp_valid, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    resp_ready = 1'b1;
    got.delete();
    repeat (6) tick();
    check("t6_no_stale", got.size(), 0);
    check("t6_issue_ready", issue_ready, 1'b1);

    // randomized traffic against the model
    do_reset();
    got.delete();
    avail[0] = 0;
    avail[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      clr_in();
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_port  = 1'($urandom_range(0, 1));
      resp_ready  = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < 2; p++) begin
        if (avail[p] > 0 && $urandom_range(0, 2) == 0 &&
            ((p == 0) ? rq0.size() : rq1.size()) < RD) begin
          send(p, ($urandom_range(0, 1) == 1) ? HEAP_OP_DEQUE_MAX : HEAP_OP_DEQUE_MIN,
               $urandom(), 6'($urandom_range(0, 63)));
          avail[p]--;
        end else if ($urandom_range(0, 9) == 0) begin
          send(p, HEAP_OP_ENQUE, $urandom(), 6'($urandom_range(0, 63)));
        end
      end
      fired = issue_valid && issue_ready;
      fport = issue_port;
      tick();
      if (fired) avail[fport]++;
    end
    clr_in();
    resp_ready = 1'b1;
    repeat (30) tick();
    check("rand_traffic_flowed", got.size() > 200, 1'b1);
    check("rand_no_overflow", err_overflow, 1'b0);
    check("rand_no_unexpected", err_unexpected, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bbq_resp_collector.md
Name: bbq_resp_collector

Overview:
Return-path companion to the BBQ enqueue/dequeue router. The router steers one dequeue and one enqueue per cycle onto two heap ports, alternating which port takes the dequeue. This block takes the two heap response streams and discards enqueue acknowledgements. It merges dequeue results back into a single in-order output stream with a ready/valid handshake, so results leave in the order their dequeues were issued.

Parameters:
DWIDTH, 32, width of heap element data
PRIOR_WIDTH, 6, width of heap element priority
TAG_DEPTH, 8, entries in issue-order tag FIFO (power of 2)
RESP_DEPTH, 4, entries in each per-port response FIFO (power of 2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
issue_valid  in  1  a dequeue was issued to a heap port this cycle
issue_port  in  1  port that took the dequeue (0 or 1)
issue_ready  out  1  tag FIFO can accept an issue
in_0_valid  in  1  heap 0 response valid
in_0_op_type  in  heap_op_t  heap 0 response op (from heap_ops package)
in_0_he_data  in  DWIDTH  heap 0 response data
in_0_he_priority  in  PRIOR_WIDTH  heap 0 response priority
in_1_valid / in_1_op_type / in_1_he_data / in_1_he_priority  in  as port 0  heap 1 response
resp_valid  out  1  merged dequeue result valid
resp_ready  in  1  downstream accepts result
resp_data  out  DWIDTH  result data
resp_priority  out  PRIOR_WIDTH  result priority
err_overflow  out  1  sticky: response dropped, FIFO full
err_unexpected  out  1  sticky: response with no outstanding dequeue on that port

Behaviour:
- Reset (async, rst high): all FIFO pointers 0, outstanding counters 0, output register empty. resp_valid=0, resp_data=0, resp_priority=0, err_overflow=0, err_unexpected=0. issue_ready=1 after reset. Reset mid-operation discards all queued tags and results.
- Issue: when issue_valid && issue_ready, push issue_port into tag FIFO and increment outstanding[issue_port]. issue_ready = !tag_full. An issue_valid while full is ignored, and the issuer must hold it.
- Response filter: in_p_valid with in_p_op_type == HEAP_OP_ENQUE is ignored with no side effects. Any other op type is a dequeue result.
- Dequeue result on port p:
  - If outstanding[p] is 0 at the start of the cycle: drop, set err_unexpected. An issue to p in the same cycle does not count; a response must trail its issue by at least 1 cycle.
  - Else if FIFO p is full and the result is not being consumed this cycle: drop, set err_overflow, leave outstanding[p] unchanged.
  - Else push into FIFO p and decrement outstanding[p].
  - Issue and accepted response on the same port in the same cycle leave the counter unchanged. Both ports may push in the same cycle.
- Merge: head tag h selects FIFO h. The output register loads when it is empty, or when it is being drained (resp_valid && resp_ready), and FIFO h is non-empty. A load pops FIFO h and the tag FIFO together.
  - If FIFO h is empty, the output stalls even when the other FIFO holds data. Strict issue order.
- Output handshake: resp_valid holds and data stays stable until resp_ready. Back-to-back transfers sustain 1 result per cycle.
- Latency (base): response valid in cycle N gives resp_valid in cycle N+2, provided the tag is at the head and the output register is free.
- Pointers are log2(DEPTH)+1 bits and wrap naturally; full/empty come from the MSB compare.
- Outstanding counters are $clog2(TAG_DEPTH+1) bits and saturate at 0 (no underflow).
- Error flags clear only on reset.

Optional Feature:
Macro BBQ_RESP_BYPASS_EN.
- Defined: when FIFO h is empty, the head tag is h, the output register is free or draining, and an accepted dequeue result arrives on port h, that result loads the output register directly. It skips FIFO h and the tag pops the same cycle. Latency becomes N+1.
- Undefined: every result passes through its FIFO; latency N+2.
- Ordering, error semantics and all other behaviour are identical either way.

Test Plan:
- Reset, then issue port0, then a port0 dequeue response D=0xA5 P=3 two cycles later, resp_ready=1 -> resp_valid in cycle N+2 (N+1 with BBQ_RESP_BYPASS_EN), data 0xA5, priority 3, one cycle only.
- Issue ports 0,1,0. Port1 responds (0x11) before the two port0 responses (0x20, 0x30) -> output order 0x20, 0x11, 0x30. No output until 0x20 arrives.
- Port0 response with op_type=HEAP_OP_ENQUE -> no FIFO write, no output, no error flag.
- Port1 dequeue response with no outstanding issue -> dropped, err_unexpected=1, stays 1 until rst.
- resp_ready=0, issue 6 to port0, 6 port0 responses with RESP_DEPTH=4 -> 4 queued plus 1 in the output register, 6th dropped, err_overflow=1. Issue 8 more -> issue_ready=0 once 8 tags are pending.
- Assert rst mid-stream with 3 results queued -> resp_valid=0 immediately (async). After release no stale results appear, and issue_ready=1.
